fifo_drain_ctrl: RTL and testbench
==================================

FIFO_DRAIN_CTRL -- requirements
Module: fifo_drain_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of the FIFO read data and the output stream data.
REQ-002 Clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 Rst  input  1  reset, synchronous and active-high.
REQ-004 Enable  input  1  drain enable; 1 = fetch words from the FIFO, 0 = stop fetching and flush held words.
REQ-005 fifoEmpty  input  1  EMPTY flag from the FIFO read side.
REQ-006 fifoData  input  DATA_WIDTH  FIFO dataOut; valid the cycle after the cycle in which fifoRd was high.
REQ-007 fifoRd  output  1  FIFO read strobe; combinational from registered state and fifoEmpty.
REQ-008 outData  output  DATA_WIDTH  downstream stream data.
REQ-009 outValid  output  1  downstream valid.
REQ-010 outReady  input  1  downstream ready.
REQ-011 drainIdle  output  1  high in state IDLE.
REQ-012 wordCount  output  16  count of accepted output words; present only when DRAIN_WORDCOUNT_EN is defined.

Function
REQ-013 The block SHALL implement a state machine with states IDLE, DRAIN and FLUSH.
- IDLE -> DRAIN when Enable=1.
- DRAIN -> FLUSH when Enable=0.
- FLUSH -> DRAIN when Enable=1.
- FLUSH -> IDLE when Enable=0, no read is in flight and the skid buffer is empty.
REQ-014 The block SHALL hold read words in a 2-entry skid buffer.
- occ = number of stored words, 0..2.
- inflight = 1 when fifoRd was high in the previous cycle.
REQ-015 fifoRd SHALL be 1 only when all of the following hold: state=DRAIN, fifoEmpty=0, and occ+inflight < 2 after counting any output handshake in the same cycle.
REQ-016 When inflight=1, fifoData SHALL be written into the skid buffer at the next free entry.
REQ-017 outValid SHALL be 1 whenever occ>0; outData SHALL be the oldest entry.
REQ-018 A word is accepted when outValid=1 and outReady=1; it SHALL then be popped, in FIFO order.
REQ-019 outData SHALL stay stable while outValid=1 and outReady=0.
REQ-020 A push and a pop in the same cycle SHALL leave occ unchanged and preserve order.
REQ-021 Sustained throughput SHALL be one word per cycle when outReady=1 and fifoEmpty=0.
REQ-022 Latency from the first fifoRd to the first outValid SHALL be 2 cycles.
REQ-023 When Enable falls while a read is in flight, the returned word SHALL still be captured and delivered during FLUSH.
REQ-024 The block SHALL never issue a read while fifoEmpty=1, and SHALL never overflow the skid buffer; words are never dropped or duplicated.

Reset
REQ-025 On Rst=1 at a clock edge:
- state=IDLE, occ=0, inflight=0, wordCount=0.
- Outputs: fifoRd=0, outValid=0, outData=0, drainIdle=1.
REQ-026 Rst SHALL override every other input, and SHALL discard held and in-flight words when asserted mid-operation.

Configuration
REQ-027 With DRAIN_WORDCOUNT_EN defined, wordCount SHALL increment by 1 on each accepted word and wrap from 0xFFFF to 0; Rst clears it.
REQ-028 Without DRAIN_WORDCOUNT_EN, the wordCount port and its counter SHALL be absent; all other behaviour is identical.

Verification
REQ-029 Streaming: FIFO preloaded with 0x11..0x88, Enable=1, outReady=1 -> outValid first on cycle 2 after the first fifoRd; 8 words in order on consecutive cycles; wordCount=8; fifoRd stays 0 once fifoEmpty=1.
REQ-030 Backpressure: FIFO holds 5 words, outReady=0 for 6 cycles, then 1 -> at most 2 reads issued while stalled; outData holds 0x11 steady; all 5 words delivered in order after release.
REQ-031 Flush: Enable drops in the cycle fifoRd=1 with occ=1 -> FLUSH; both words delivered; no further fifoRd; drainIdle=1 one cycle after the last handshake.
REQ-032 Empty boundary: fifoEmpty toggles 0/1 every cycle with outReady=1 -> fifoRd never high while fifoEmpty=1; no duplicate or lost words.
REQ-033 Reset mid-operation: Rst=1 for 1 cycle with occ=2 -> next cycle outValid=0, fifoRd=0, drainIdle=1, wordCount=0.
REQ-034 Macro build: compile with and without DRAIN_WORDCOUNT_EN -> run 0x10000+3 words; wordCount=3 in the macro build; output streams identical in both builds.

Source files
------------

// File: rtl/fifo_drain_ctrl.sv
// FIFO read-side drain controller with a 2-entry skid buffer.
// Optional word counter enabled by DRAIN_WORDCOUNT_EN.
module fifo_drain_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Enable,
    input  logic                  fifoEmpty,
    input  logic [DATA_WIDTH-1:0] fifoData,
    output logic                  fifoRd,
    output logic [DATA_WIDTH-1:0] outData,
    output logic                  outValid,
    input  logic                  outReady,
`ifdef DRAIN_WORDCOUNT_EN
    output logic [15:0]           wordCount,
`endif
    output logic                  drainIdle
);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        FLUSH
    } state_t;

    state_t                r_state;
    logic [1:0]            r_occ;
    logic                  r_inflight;
    logic                  r_idle;
    logic [DATA_WIDTH-1:0] r_buf0;
    logic [DATA_WIDTH-1:0] r_buf1;

    logic       w_pop;
    logic       w_push;
    logic [1:0] w_occ_nxt;

    assign w_pop     = (r_occ != 2'd0) && outReady;
    assign w_push    = r_inflight;
    assign w_occ_nxt = r_occ + {1'b0, w_push} - {1'b0, w_pop};

    // A new read becomes next cycle's in-flight word, so it must fit
    // alongside whatever the buffer will hold after this cycle.
    assign fifoRd    = (r_state == DRAIN) && !fifoEmpty && (w_occ_nxt < 2'd2);

    assign outValid  = (r_occ != 2'd0);
    assign outData   = outValid ? r_buf0 : '0;
    assign drainIdle = r_idle;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state    <= IDLE;
            r_idle     <= 1'b1;
            r_occ      <= 2'd0;
            r_inflight <= 1'b0;
            r_buf0     <= '0;
            r_buf1     <= '0;
        end else begin
            r_occ      <= w_occ_nxt;
            r_inflight <= fifoRd;

            if (w_pop) begin
                r_buf0 <= r_buf1;
                if (w_push) begin
                    if (r_occ == 2'd1) r_buf0 <= fifoData;
                    else               r_buf1 <= fifoData;
                end
            end else if (w_push) begin
                if (r_occ == 2'd0) r_buf0 <= fifoData;
                else               r_buf1 <= fifoData;
            end

            unique case (r_state)
                IDLE: begin
                    if (Enable) begin
                        r_state <= DRAIN;
                        r_idle  <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (!Enable) r_state <= FLUSH;
                end
                FLUSH: begin
                    // Leave as soon as the last held word is handed off.
                    if (Enable) begin
                        r_state <= DRAIN;
                    end else if (!r_inflight && (w_occ_nxt == 2'd0)) begin
                        r_state <= IDLE;
                        r_idle  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_idle  <= 1'b1;
                end
            endcase
        end
    end

`ifdef DRAIN_WORDCOUNT_EN
    logic [15:0] r_wcnt;

    always_ff @(posedge Clk) begin
        if (Rst)        r_wcnt <= 16'd0;
        else if (w_pop) r_wcnt <= r_wcnt + 16'd1;
    end

    assign wordCount = r_wcnt;
`endif

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Randomised and directed bench for fifo_drain_ctrl against a
// queue-based model of the drain controller.
module tb_fifo_drain_ctrl;

    localparam int W = 32;

    logic         Clk = 1'b0;
    logic         Rst;
    logic         Enable;
    logic         fifoEmpty;
    logic [W-1:0] fifoData;
    logic         fifoRd;
    logic [W-1:0] outData;
    logic         outValid;
    logic         outReady;
    logic         drainIdle;
`ifdef DRAIN_WORDCOUNT_EN
    logic [15:0]  wordCount;
`endif

    fifo_drain_ctrl #(.DATA_WIDTH(W)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Enable    (Enable),
        .fifoEmpty (fifoEmpty),
        .fifoData  (fifoData),
        .fifoRd    (fifoRd),
        .outData   (outData),
        .outValid  (outValid),
        .outReady  (outReady),
`ifdef DRAIN_WORDCOUNT_EN
        .wordCount (wordCount),
`endif
        .drainIdle (drainIdle)
    );

    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] src_q[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] out_log[$];
    logic [W-1:0] ref_q[$];
    bit           pend;
    logic [W-1:0] pend_w;
    int           mode;
    logic [15:0]  cnt;
    bit           force_empty;
    int           cyc;
    int           first_rd;
    int           first_val;
    int           rd_cnt;
    int           last_pop;
    int           idle_rise;
    bit           prev_idle;
    int           n_deliv;

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic cycle(input bit rst, input bit en, input bit rdy);
        bit           e_val;
        bit           e_pop;
        bit           e_rd;
        bit           old_pend;
        logic [W-1:0] old_w;
        logic [W-1:0] w;
        @(negedge Clk);
        Rst       = rst;
        Enable    = en;
        outReady  = rdy;
        fifoEmpty = force_empty || (src_q.size() == 0);
        fifoData  = pend ? pend_w : W'($urandom);
        #1;
        e_val = (exp_q.size() > 0);
        e_pop = e_val && rdy;
        e_rd  = (mode == 1) && !fifoEmpty &&
                ((exp_q.size() + int'(pend) - int'(e_pop)) < 2);
        chk("fifoRd", W'(fifoRd), W'(e_rd));
        chk("outValid", W'(outValid), W'(e_val));
        chk("outData", outData, e_val ? exp_q[0] : '0);
        chk("drainIdle", W'(drainIdle), W'(mode == 0));
`ifdef DRAIN_WORDCOUNT_EN
        chk("wordCount", W'(wordCount), W'(cnt));
`endif
        if (fifoEmpty) chk("rd_when_empty", W'(fifoRd), '0);
        if (fifoRd) rd_cnt++;
        if (fifoRd && first_rd < 0) first_rd = cyc;
        if (outValid && first_val < 0) first_val = cyc;
        if (drainIdle && !prev_idle) idle_rise = cyc;
        prev_idle = drainIdle;
        if (e_pop) begin
            out_log.push_back(exp_q[0]);
            last_pop = cyc;
            n_deliv++;
        end
        @(posedge Clk);
        w = '0;
        if (fifoRd && src_q.size() > 0) w = src_q.pop_front();
        if (rst) begin
            exp_q.delete();
            pend = 1'b0;
            mode = 0;
            cnt  = '0;
        end else begin
            old_pend = pend;
            old_w    = pend_w;
            if (e_pop) begin
                void'(exp_q.pop_front());
                cnt = cnt + 16'd1;
            end
            if (old_pend) exp_q.push_back(old_w);
            pend   = e_rd;
            pend_w = w;
            case (mode)
                0: if (en) mode = 1;
                1: if (!en) mode = 2;
                default: begin
                    if (en) mode = 1;
                    else if (!old_pend && exp_q.size() == 0) mode = 0;
                end
            endcase
        end
        cyc++;
    endtask

    task automatic check_log(input string nm);
        chk({nm, "_len"}, W'(out_log.size()), W'(ref_q.size()));
        for (int i = 0; i < ref_q.size() && i < out_log.size(); i++)
            chk(nm, out_log[i], ref_q[i]);
    endtask

    initial begin
        Rst = 1'b1; Enable = 1'b0; outReady = 1'b0;
        fifoEmpty = 1'b1; fifoData = '0;
        pend = 1'b0; pend_w = '0; mode = 0; cnt = '0;
        force_empty = 1'b0; cyc = 0; rd_cnt = 0;
        first_rd = -1; first_val = -1;
        last_pop = -1; idle_rise = -1; prev_idle = 1'b1; n_deliv = 0;

        // reset
        cycle(1, 0, 0);
        cycle(1, 1, 1);
        cycle(0, 0, 0);
        #1;
        chk("rst_idle", W'(drainIdle), W'(1));
        chk("rst_valid", W'(outValid), W'(0));
        chk("rst_rd", W'(fifoRd), W'(0));
        chk("rst_data", outData, W'(0));

        // streaming
        out_log.delete(); ref_q.delete();
        for (int i = 1; i <= 8; i++) begin
            src_q.push_back(W'(8'h11 * i));
            ref_q.push_back(W'(8'h11 * i));
        end
        first_rd = -1; first_val = -1;
        for (int i = 0; i < 14; i++) cycle(0, 1, 1);
        chk("stream_latency", W'(first_val - first_rd), W'(2));
        chk("stream_last_gap", W'(last_pop - (first_val + 7)), W'(0));
        check_log("stream");
`ifdef DRAIN_WORDCOUNT_EN
        #1 chk("stream_wcnt", W'(wordCount), W'(8));
`endif
        for (int i = 0; i < 3; i++) cycle(0, 0, 1);

        // backpressure
        out_log.delete(); ref_q.delete();
        for (int i = 1; i <= 5; i++) begin
            src_q.push_back(W'(8'h11 * i));
            ref_q.push_back(W'(8'h11 * i));
        end
        rd_cnt = 0;
        for (int i = 0; i < 6; i++) cycle(0, 1, 0);
        chk("bp_rds", W'(rd_cnt <= 2), W'(1));
        #1 chk("bp_hold", outData, W'(32'h11));
        for (int i = 0; i < 8; i++) cycle(0, 1, 1);
        check_log("bp");
        for (int i = 0; i < 3; i++) cycle(0, 0, 1);

        // flush with a read in flight
        out_log.delete(); ref_q.delete();
        src_q.push_back(32'hA5A5_0001);
        ref_q.push_back(32'hA5A5_0001);
        ref_q.push_back(32'hA5A5_0002);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0);
        src_q.push_back(32'hA5A5_0002);
        rd_cnt = 0;
        cycle(0, 0, 0);
        chk("flush_rd", W'(rd_cnt), W'(1));
        rd_cnt = 0;
        for (int i = 0; i < 4; i++) cycle(0, 0, 1);
        chk("flush_no_rd", W'(rd_cnt), W'(0));
        chk("flush_idle_gap", W'(idle_rise - last_pop), W'(1));
        check_log("flush");

        // empty flag toggling every cycle
        out_log.delete(); ref_q.delete();
        for (int i = 0; i < 20; i++) begin
            logic [W-1:0] v;
            v = W'($urandom);
            src_q.push_back(v);
            ref_q.push_back(v);
        end
        for (int i = 0; i < 60; i++) begin
            force_empty = i[0];
            cycle(0, 1, 1);
        end
        force_empty = 1'b0;
        for (int i = 0; i < 4; i++) cycle(0, 0, 1);
        check_log("toggle");

        // random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) src_q.push_back(W'($urandom));
            force_empty = ($urandom_range(0, 3) == 0);
            cycle(0, $urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1);
        end
        force_empty = 1'b0;
        src_q.delete();
        for (int i = 0; i < 6; i++) cycle(0, 0, 1);
        #1 chk("rand_idle", W'(drainIdle), W'(1));

        // reset with a full skid buffer
        for (int i = 0; i < 4; i++) src_q.push_back(W'(i + 100));
        for (int i = 0; i < 5; i++) cycle(0, 1, 0);
        #1 chk("pre_rst_full", W'(exp_q.size()), W'(2));
        cycle(1, 1, 0);
        #1;
        chk("mid_rst_valid", W'(outValid), W'(0));
        chk("mid_rst_rd", W'(fifoRd), W'(0));
        chk("mid_rst_idle", W'(drainIdle), W'(1));
`ifdef DRAIN_WORDCOUNT_EN
        chk("mid_rst_wcnt", W'(wordCount), W'(0));
`endif
        src_q.delete();
        for (int i = 0; i < 2; i++) cycle(0, 0, 1);

        // counter wrap run
        out_log.delete();
        n_deliv = 0;
        for (int i = 0; i < 32'h10003; i++) src_q.push_back(W'(i));
        for (int i = 0; i < 32'h10003 + 6; i++) cycle(0, 1, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1);
        chk("wrap_count", W'(n_deliv), W'(32'h10003));
        chk("wrap_last", out_log[out_log.size() - 1], W'(32'h10002));
`ifdef DRAIN_WORDCOUNT_EN
        #1 chk("wrap_wcnt", W'(wordCount), W'(3));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
